// File: rtl/idma_reg_2d_launch_queue.sv
// Multi-stream launch queue: per-stream descriptor FIFOs and ID counters feeding one
// round-robin 2D expansion engine that emits 1D back-end requests.
module idma_reg_2d_launch_queue #(
    parameter int unsigned NumStreams  = 4,
    parameter int unsigned QueueDepth  = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned RepWidth    = 32,
    parameter int unsigned IdWidth     = 32,
    parameter int unsigned StreamWidth = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          launch_valid_i,
    output logic                          launch_ready_o,
    input  logic [StreamWidth-1:0]        launch_stream_i,
    input  logic [AddrWidth-1:0]          launch_src_addr_i,
    input  logic [AddrWidth-1:0]          launch_dst_addr_i,
    input  logic [LenWidth-1:0]           launch_length_i,
    input  logic [AddrWidth-1:0]          launch_src_stride_i,
    input  logic [AddrWidth-1:0]          launch_dst_stride_i,
    input  logic [RepWidth-1:0]           launch_reps_i,
    output logic [IdWidth-1:0]            launch_id_o,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [StreamWidth-1:0]        req_stream_o,
    output logic [AddrWidth-1:0]          req_src_addr_o,
    output logic [AddrWidth-1:0]          req_dst_addr_o,
    output logic [LenWidth-1:0]           req_length_o,
    output logic                          req_last_o,
    input  logic                          cmpl_valid_i,
    input  logic [StreamWidth-1:0]        cmpl_stream_i,
    input  logic                          cmpl_last_i,
    output logic [NumStreams*IdWidth-1:0] done_id_o,
    output logic [NumStreams-1:0]         busy_o
);

    localparam int unsigned PtrWidth = $clog2(QueueDepth);

    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [AddrWidth-1:0] src_stride;
        logic [AddrWidth-1:0] dst_stride;
        logic [LenWidth-1:0]  len;
        logic [RepWidth-1:0]  reps;
    } desc_t;

    typedef enum logic {IDLE, ISSUE} state_e;

    desc_t                mem_q     [NumStreams][QueueDepth];
    logic [PtrWidth:0]    wr_ptr_q  [NumStreams];
    logic [PtrWidth:0]    rd_ptr_q  [NumStreams];
    logic [IdWidth-1:0]   next_id_q [NumStreams];
    logic [IdWidth-1:0]   done_id_q [NumStreams];

    state_e               state_q, state_d;
    logic [StreamWidth-1:0] rr_q, rr_d;
    logic [StreamWidth-1:0] cur_q, cur_d;
    logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
    logic [AddrWidth-1:0] sstride_q, sstride_d, dstride_q, dstride_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [RepWidth-1:0]  rep_cnt_q, rep_cnt_d, last_rep_q, last_rep_d;

    logic [NumStreams-1:0] empty, full, push, pop, launch_sel;
    logic [StreamWidth-1:0] grant;
    logic                  any_ne, found, hs, last_rep, load;
    desc_t                 head, launch_desc;

    always_comb begin
        for (int unsigned s = 0; s < NumStreams; s++) begin
            empty[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
            full[s]  = (wr_ptr_q[s][PtrWidth] != rd_ptr_q[s][PtrWidth]) &&
                       (wr_ptr_q[s][PtrWidth-1:0] == rd_ptr_q[s][PtrWidth-1:0]);
        end
    end

    // Out-of-range streams match no entry: ready stays high and the launch is dropped.
    always_comb begin
        launch_sel     = '0;
        launch_ready_o = 1'b1;
        launch_id_o    = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            if (launch_stream_i == StreamWidth'(s)) begin
                launch_sel[s]  = 1'b1;
                launch_ready_o = !full[s];
                launch_id_o    = next_id_q[s];
            end
        end
        push = launch_sel & ~full & {NumStreams{launch_valid_i}};
    end

    assign launch_desc = '{src: launch_src_addr_i, dst: launch_dst_addr_i,
                           src_stride: launch_src_stride_i, dst_stride: launch_dst_stride_i,
                           len: launch_length_i, reps: launch_reps_i};

    // Round-robin: first pass covers streams at/after the pointer, second pass wraps.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            if (!found && !empty[s] && (StreamWidth'(s) >= rr_q)) begin
                found = 1'b1;
                grant = StreamWidth'(s);
            end
        end
        for (int unsigned s = 0; s < NumStreams; s++) begin
            if (!found && !empty[s]) begin
                found = 1'b1;
                grant = StreamWidth'(s);
            end
        end
        any_ne = found;
        head   = mem_q[grant][rd_ptr_q[grant][PtrWidth-1:0]];
    end

    assign hs       = (state_q == ISSUE) && req_ready_i;
    assign last_rep = (rep_cnt_q == last_rep_q);
    assign load     = any_ne && ((state_q == IDLE) || (hs && last_rep));

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cur_d      = cur_q;
        src_d      = src_q;
        dst_d      = dst_q;
        sstride_d  = sstride_q;
        dstride_d  = dstride_q;
        len_d      = len_q;
        rep_cnt_d  = rep_cnt_q;
        last_rep_d = last_rep_q;
        pop        = '0;
        if (load) begin
            state_d    = ISSUE;
            cur_d      = grant;
            src_d      = head.src;
            dst_d      = head.dst;
            sstride_d  = head.src_stride;
            dstride_d  = head.dst_stride;
            len_d      = head.len;
            rep_cnt_d  = '0;
            last_rep_d = (head.reps == '0) ? '0 : head.reps - RepWidth'(1);
            rr_d       = (grant == StreamWidth'(NumStreams - 1)) ? '0 : grant + StreamWidth'(1);
            for (int unsigned s = 0; s < NumStreams; s++) begin
                pop[s] = (grant == StreamWidth'(s));
            end
        end else if (hs) begin
            if (last_rep) begin
                state_d = IDLE;
            end else begin
                src_d     = src_q + sstride_q;
                dst_d     = dst_q + dstride_q;
                rep_cnt_d = rep_cnt_q + RepWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cur_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            sstride_q  <= '0;
            dstride_q  <= '0;
            len_q      <= '0;
            rep_cnt_q  <= '0;
            last_rep_q <= '0;
            for (int unsigned s = 0; s < NumStreams; s++) begin
                wr_ptr_q[s]  <= '0;
                rd_ptr_q[s]  <= '0;
                next_id_q[s] <= IdWidth'(1);
                done_id_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_q      <= cur_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            sstride_q  <= sstride_d;
            dstride_q  <= dstride_d;
            len_q      <= len_d;
            rep_cnt_q  <= rep_cnt_d;
            last_rep_q <= last_rep_d;
            for (int unsigned s = 0; s < NumStreams; s++) begin
                if (push[s]) begin
                    wr_ptr_q[s]  <= wr_ptr_q[s] + (PtrWidth+1)'(1);
                    next_id_q[s] <= next_id_q[s] + IdWidth'(1);
                end
                if (pop[s]) begin
                    rd_ptr_q[s] <= rd_ptr_q[s] + (PtrWidth+1)'(1);
                end
                if (cmpl_valid_i && cmpl_last_i && (cmpl_stream_i == StreamWidth'(s))) begin
                    done_id_q[s] <= done_id_q[s] + IdWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < NumStreams; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s][PtrWidth-1:0]] <= launch_desc;
            end
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < NumStreams; s++) begin
            done_id_o[s*IdWidth +: IdWidth] = done_id_q[s];
            busy_o[s] = (done_id_q[s] != (next_id_q[s] - IdWidth'(1)));
        end
    end

    assign req_valid_o    = (state_q == ISSUE);
    assign req_last_o     = (state_q == ISSUE) && last_rep;
    assign req_stream_o   = cur_q;
    assign req_src_addr_o = src_q;
    assign req_dst_addr_o = dst_q;
    assign req_length_o   = len_q;

endmodule

// File: tb/tb_idma_reg_2d_launch_queue.sv
// Directed bench for idma_reg_2d_launch_queue: expected 1D requests are queued at launch
// time and compared against each back-end handshake.
module tb_idma_reg_2d_launch_queue;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         launch_valid_i;
    logic         launch_ready_o;
    logic [1:0]   launch_stream_i;
    logic [63:0]  launch_src_addr_i, launch_dst_addr_i;
    logic [31:0]  launch_length_i;
    logic [63:0]  launch_src_stride_i, launch_dst_stride_i;
    logic [31:0]  launch_reps_i;
    logic [31:0]  launch_id_o;
    logic         req_valid_o;
    logic         req_ready_i;
    logic [1:0]   req_stream_o;
    logic [63:0]  req_src_addr_o, req_dst_addr_o;
    logic [31:0]  req_length_o;
    logic         req_last_o;
    logic         cmpl_valid_i;
    logic [1:0]   cmpl_stream_i;
    logic         cmpl_last_i;
    logic [127:0] done_id_o;
    logic [3:0]   busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  s;
        logic [63:0] src, dst, ss, ds;
        logic [31:0] len, reps;
    } desc_t;

    typedef struct {
        logic [1:0]  s;
        logic [63:0] src, dst;
        logic [31:0] len;
        logic        last;
    } exp_t;

    exp_t sb[$];

    idma_reg_2d_launch_queue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
        .launch_stream_i(launch_stream_i), .launch_src_addr_i(launch_src_addr_i),
        .launch_dst_addr_i(launch_dst_addr_i), .launch_length_i(launch_length_i),
        .launch_src_stride_i(launch_src_stride_i), .launch_dst_stride_i(launch_dst_stride_i),
        .launch_reps_i(launch_reps_i), .launch_id_o(launch_id_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_stream_o(req_stream_o),
        .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o),
        .req_length_o(req_length_o), .req_last_o(req_last_o),
        .cmpl_valid_i(cmpl_valid_i), .cmpl_stream_i(cmpl_stream_i), .cmpl_last_i(cmpl_last_i),
        .done_id_o(done_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t mk(input logic [1:0] s, input logic [63:0] src, input logic [63:0] dst,
                                 input logic [31:0] len, input logic [63:0] ss, input logic [63:0] ds,
                                 input logic [31:0] reps);
        desc_t d;
        d.s = s; d.src = src; d.dst = dst; d.len = len; d.ss = ss; d.ds = ds; d.reps = reps;
        return d;
    endfunction

    task automatic expect_desc(input desc_t d);
        int unsigned n;
        n = (d.reps == 0) ? 1 : d.reps;
        for (int unsigned r = 0; r < n; r++) begin
            exp_t e;
            e.s    = d.s;
            e.src  = d.src + 64'(r) * d.ss;
            e.dst  = d.dst + 64'(r) * d.ds;
            e.len  = d.len;
            e.last = (r == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Starts and returns at posedge+1.
    task automatic launch(input desc_t d, input logic [31:0] exp_id, input logic exp_ready);
        launch_valid_i      = 1'b1;
        launch_stream_i     = d.s;
        launch_src_addr_i   = d.src;
        launch_dst_addr_i   = d.dst;
        launch_length_i     = d.len;
        launch_src_stride_i = d.ss;
        launch_dst_stride_i = d.ds;
        launch_reps_i       = d.reps;
        @(negedge clk_i);
        check("launch_ready", launch_ready_o, exp_ready);
        check("launch_id", launch_id_o, exp_id);
        step();
        launch_valid_i = 1'b0;
    endtask

    task automatic cmpl(input logic [1:0] s, input logic last);
        cmpl_valid_i  = 1'b1;
        cmpl_stream_i = s;
        cmpl_last_i   = last;
        step();
        cmpl_valid_i  = 1'b0;
        cmpl_last_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sb.delete();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (!req_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, req_valid_o, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && req_valid_o && req_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_req", req_valid_o, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("req_stream", req_stream_o, e.s);
                check("req_src", req_src_addr_o, e.src);
                check("req_dst", req_dst_addr_o, e.dst);
                check("req_len", req_length_o, e.len);
                check("req_last", req_last_o, e.last);
            end
        end
    end

    initial begin
        desc_t d;
        desc_t q1 [4];
        desc_t q5 [6];

        rst_i = 1'b1; launch_valid_i = 1'b0; launch_stream_i = '0;
        launch_src_addr_i = '0; launch_dst_addr_i = '0; launch_length_i = '0;
        launch_src_stride_i = '0; launch_dst_stride_i = '0; launch_reps_i = '0;
        req_ready_i = 1'b0; cmpl_valid_i = 1'b0; cmpl_stream_i = '0; cmpl_last_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        check("rst_req_valid", req_valid_o, 1'b0);
        check("rst_req_last", req_last_o, 1'b0);
        check("rst_req_src", req_src_addr_o, 64'h0);
        check("rst_busy", busy_o, 4'h0);
        check("rst_done_id", done_id_o, 128'h0);
        check("rst_launch_ready", launch_ready_o, 1'b1);
        step();

        // Single 1D transfer, reps=0 acts as 1, latency t+2.
        d = mk(2'd0, 64'h1000, 64'h2000, 32'd64, 64'h0, 64'h0, 32'd0);
        launch(d, 32'd1, 1'b1);
        expect_desc(d);
        @(negedge clk_i);
        check("t1_valid_t1", req_valid_o, 1'b0);
        @(negedge clk_i);
        check("t1_valid_t2", req_valid_o, 1'b1);
        check("t1_last", req_last_o, 1'b1);
        check("t1_busy", busy_o[0], 1'b1);
        step();
        req_ready_i = 1'b1;
        wait_drain("t1_drain");
        check("t1_busy_inflight", busy_o[0], 1'b1);
        step();
        cmpl(2'd0, 1'b1);
        @(negedge clk_i);
        check("t1_done_id0", done_id_o[31:0], 32'd1);
        check("t1_busy_after", busy_o[0], 1'b0);

        // 2D expansion with a 5-cycle backpressure hold on the first rep.
        step();
        req_ready_i = 1'b0;
        d = mk(2'd0, 64'h100, 64'h800, 32'd16, 64'h40, 64'h80, 32'd3);
        launch(d, 32'd2, 1'b1);
        expect_desc(d);
        wait_valid("t2_valid");
        repeat (5) begin
            @(negedge clk_i);
            check("t2_hold_valid", req_valid_o, 1'b1);
            check("t2_hold_src", req_src_addr_o, 64'h100);
            check("t2_hold_dst", req_dst_addr_o, 64'h800);
            check("t2_hold_last", req_last_o, 1'b0);
        end
        step();
        req_ready_i = 1'b1;
        wait_drain("t2_drain");
        step();
        cmpl(2'd0, 1'b0);
        cmpl(2'd0, 1'b0);
        @(negedge clk_i);
        check("t2_nonlast_done", done_id_o[31:0], 32'd1);
        check("t2_nonlast_busy", busy_o[0], 1'b1);
        step();
        cmpl(2'd0, 1'b1);
        @(negedge clk_i);
        check("t2_done_id0", done_id_o[31:0], 32'd2);
        check("t2_busy_after", busy_o[0], 1'b0);

        // Fill stream 1 while the engine is stalled on stream 3.
        step();
        do_reset();
        req_ready_i = 1'b0;
        d = mk(2'd3, 64'h3000, 64'h4000, 32'd8, 64'h0, 64'h0, 32'd1);
        launch(d, 32'd1, 1'b1);
        expect_desc(d);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            q1[i] = mk(2'd1, 64'h5000 + 64'(i) * 64'h10, 64'h6000 + 64'(i) * 64'h10, 32'd4, 64'h0, 64'h0, 32'd1);
            launch(q1[i], 32'(i + 1), 1'b1);
        end
        launch(mk(2'd1, 64'h7000, 64'h7000, 32'd4, 64'h0, 64'h0, 32'd1), 32'd5, 1'b0);
        d = mk(2'd2, 64'h8000, 64'h9000, 32'd12, 64'h0, 64'h0, 32'd1);
        launch(d, 32'd1, 1'b1);
        @(negedge clk_i);
        check("t4_busy", busy_o, 4'b1110);
        expect_desc(q1[0]);
        expect_desc(d);
        expect_desc(q1[1]);
        expect_desc(q1[2]);
        expect_desc(q1[3]);
        step();
        req_ready_i = 1'b1;
        wait_drain("t4_drain");

        // Round-robin across three streams without bubbles.
        step();
        do_reset();
        req_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            q5[i] = mk(2'(i % 3), 64'hA000 + 64'(i) * 64'h100, 64'hB000 + 64'(i) * 64'h100, 32'(i + 1), 64'h0, 64'h0, 32'd1);
            launch(q5[i], 32'(i / 3 + 1), 1'b1);
            expect_desc(q5[i]);
        end
        wait_valid("t5_valid");
        step();
        req_ready_i = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            check("t5_nobubble", req_valid_o, 1'b1);
        end
        wait_drain("t5_drain");

        // Reset mid-issue with queued work; completion during reset must be ignored.
        step();
        do_reset();
        req_ready_i = 1'b0;
        launch(mk(2'd0, 64'hC000, 64'hD000, 32'd32, 64'h20, 64'h20, 32'd4), 32'd1, 1'b1);
        launch(mk(2'd1, 64'hE000, 64'hF000, 32'd32, 64'h0, 64'h0, 32'd1), 32'd1, 1'b1);
        wait_valid("t6_valid");
        step();
        rst_i = 1'b1;
        cmpl_valid_i = 1'b1; cmpl_stream_i = 2'd0; cmpl_last_i = 1'b1;
        step();
        rst_i = 1'b0;
        cmpl_valid_i = 1'b0; cmpl_last_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
        check("t6_req_valid", req_valid_o, 1'b0);
        check("t6_busy", busy_o, 4'h0);
        check("t6_done_id", done_id_o, 128'h0);
        step();
        d = mk(2'd0, 64'h1234, 64'h5678, 32'd2, 64'h0, 64'h0, 32'd1);
        launch(d, 32'd1, 1'b1);
        expect_desc(d);
        req_ready_i = 1'b1;
        wait_drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idma_reg_2d_launch_queue.md
Name: idma_reg_2d_launch_queue

Overview:
Multi-stream launch queue that sits between the register front-end and the iDMA back-end. Each stream has its own descriptor FIFO and transfer-ID counter. A single 2D expansion engine, fed round-robin across streams, turns each descriptor into `reps` 1D back-end requests. Per-stream completed IDs and busy flags are tracked for status readback.

Parameters:
- NumStreams, 4: number of independent streams (1..16).
- QueueDepth, 4: descriptors per stream FIFO (power of two, >= 2).
- AddrWidth, 64: address and stride width.
- LenWidth, 32: 1D length width.
- RepWidth, 32: repetition count width.
- IdWidth, 32: transfer ID width.
- StreamWidth, max(1, clog2(NumStreams)): derived; stream index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- launch_valid_i  in  1  launch request.
- launch_ready_o  out  1  launch accepted when high with valid.
- launch_stream_i  in  StreamWidth  target stream.
- launch_src_addr_i  in  AddrWidth  source base.
- launch_dst_addr_i  in  AddrWidth  destination base.
- launch_length_i  in  LenWidth  bytes per 1D rep.
- launch_src_stride_i  in  AddrWidth  source stride per rep.
- launch_dst_stride_i  in  AddrWidth  destination stride per rep.
- launch_reps_i  in  RepWidth  repetitions; 0 is treated as 1.
- launch_id_o  out  IdWidth  ID given to the launch in the accepting cycle.
- req_valid_o  out  1  1D request valid.
- req_ready_i  in  1  back-end ready.
- req_stream_o  out  StreamWidth  stream of the request.
- req_src_addr_o  out  AddrWidth  source address.
- req_dst_addr_o  out  AddrWidth  destination address.
- req_length_o  out  LenWidth  length.
- req_last_o  out  1  final rep of the descriptor.
- cmpl_valid_i  in  1  back-end completion pulse, one per 1D request.
- cmpl_stream_i  in  StreamWidth  completing stream.
- cmpl_last_i  in  1  echo of req_last_o for the completion.
- done_id_o  out  NumStreams*IdWidth  last completed ID per stream.
- busy_o  out  NumStreams  stream has queued, active or in-flight work.

Behaviour:
Reset (synchronous, rst_i sampled high at a clock edge):
- All FIFOs are flushed, the engine goes IDLE, and the RR pointer is set to 0.
- next_id[s] = 1 and done_id[s] = 0.
- Outputs after that edge: req_valid_o=0, req_last_o=0, all req fields 0, busy_o=0, done_id_o=0, launch_ready_o reflects empty FIFOs.
- Reset mid-operation drops any in-flight request without a handshake. Completions sampled while rst_i is high are ignored.

Launch path:
- launch_ready_o = !full[launch_stream_i] (combinational).
- An out-of-range stream gives launch_ready_o=1; the launch is discarded and launch_id_o=0.
- launch_id_o = next_id[launch_stream_i], combinational.
- On accept, the descriptor is written to the FIFO and next_id increments modulo 2^IdWidth.
- A full FIFO has no pass-through, so a push and a pop on the same full stream cannot both happen in one cycle.

Engine FSM, states IDLE and ISSUE:
- IDLE: if any FIFO is non-empty, the round-robin arbiter grants the first non-empty stream at or after the pointer. The engine loads and pops the head, moves to ISSUE, and sets the pointer to grant+1 (wrapping).
- ISSUE: req_valid_o=1. All req fields are held stable until the handshake.
- On each handshake the addresses advance by their strides (modulo 2^AddrWidth) and the rep counter increments.
- req_last_o=1 on rep max(reps,1)-1.
- On the last handshake: if any FIFO is non-empty, the next descriptor loads on the same edge (no bubble). Otherwise the engine goes to IDLE.
- Arbitration happens only at descriptor boundaries; reps of different descriptors never interleave.
- Latency: a launch accepted in cycle t with the engine idle gives req_valid_o in cycle t+2.
- length=0 descriptors are issued unchanged.

Completion:
- cmpl_valid_i && cmpl_last_i increments done_id[cmpl_stream_i] modulo 2^IdWidth.
- Non-last completions only count toward nothing; they have no effect.
- An out-of-range completion stream is ignored.
- busy_o[s] = (done_id[s] != next_id[s]-1), using modular arithmetic.
- A launch and a completion on the same stream in the same cycle both take effect.

Test Plan:
- After reset, launch stream 0 with src=0x1000, dst=0x2000, len=64, reps=0 → launch_id_o=1; one request at t+2 with req_last_o=1; busy_o[0]=1 until cmpl_last, then done_id[0]=1 and busy_o[0]=0.
- 2D launch: src=0x100, src_stride=0x40, dst=0x800, dst_stride=0x80, reps=3 → src 0x100/0x140/0x180, dst 0x800/0x880/0x900; req_last_o only on the third.
- Hold req_ready_i=0 for 5 cycles → all req fields stable; no second request appears.
- Fill stream 1 with 4 launches → launch_ready_o=0 for stream 1 while stream 2 launches still accepted; IDs 1..4 on stream 1.
- Streams 0,1,2 each queued with 2 descriptors (reps=1) → issue order 0,1,2,0,1,2 with no idle cycles between them.
- Assert rst_i for 1 cycle mid-ISSUE with FIFOs non-empty → next cycle req_valid_o=0, busy_o=0, done_id_o=0; the next launch gets ID 1.
